// File: rtl/contador.sv
// contador: 4-bit up/down/down-by-3/load counter with registered wrap pulse
//   CLK   in   clock, all state changes on rising edge
//   RESET in   synchronous active-high clear (Q=0, RCO=0)
//   ENB   in   1 = apply MODO operation, 0 = hold Q and clear RCO
//   MODO  in   00 up 1, 01 down 1, 10 down 3, 11 load D
//   D     in   parallel-load data
//   Q     out  registered count
//   RCO   out  registered one-cycle pulse on each modulo-16 wrap
module contador (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ENB,
   input  logic [1:0] MODO,
   input  logic [3:0] D,
   output logic [3:0] Q,
   output logic       RCO
);
   logic [3:0] nxt;
   logic       wrap;
   // 4-bit subtraction wraps naturally, so Q<3 in mode 10 lands on Q+13
   always_comb begin
      nxt  = MODO == 2'b00 ? Q + 4'd1 :
             MODO == 2'b01 ? Q - 4'd1 :
             MODO == 2'b10 ? Q - 4'd3 :
             MODO == 2'b11 ? D : Q;
      wrap = MODO == 2'b00 ? Q == 4'd15 :
             MODO == 2'b01 ? Q == 4'd0 :
             MODO == 2'b10 ? Q < 4'd3 : 1'b0;
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         Q   <= 4'd0;
         RCO <= 1'b0;
      end else if (ENB) begin
         Q   <= nxt;
         RCO <= wrap;
      end else begin
         RCO <= 1'b0;
      end
   end
endmodule

// File: tb/tb_contador.sv
// tb_contador: directed and random stimulus against an arithmetic reference model
module tb_contador;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enb = 1'b0;
   logic [1:0] modo = 2'b00;
   logic [3:0] d = 4'd0;
   logic [3:0] q;
   logic       rco;
   int         n_cmp = 0;
   int         n_fail = 0;
   int         mq = 0;
   bit         mr = 1'b0;
   contador dut (
      .CLK(clk),
      .RESET(rst),
      .ENB(enb),
      .MODO(modo),
      .D(d),
      .Q(q),
      .RCO(rco)
   );
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL timeout q=%0d rco=%0d required finish", q, rco);
      $fatal(1, "timeout");
   end
   // reference: plain integer arithmetic, folded back into 0..15
   task automatic model(input bit r, input bit e, input int m, input int dv);
      int nq;
      bit w;
      if (r) begin
         mq = 0;
         mr = 0;
      end else if (!e) begin
         mr = 0;
      end else begin
         w = 0;
         case (m)
            0: nq = mq + 1;
            1: nq = mq - 1;
            2: nq = mq - 3;
            default: nq = dv;
         endcase
         if (m != 3 && (nq > 15 || nq < 0)) w = 1;
         if (nq > 15) nq -= 16;
         if (nq < 0) nq += 16;
         mq = nq;
         mr = w;
      end
   endtask
   task automatic step(input string tag, input bit r, input bit e, input int m, input int dv);
      @(negedge clk);
      rst  = r;
      enb  = e;
      modo = 2'(m);
      d    = 4'(dv);
      @(posedge clk);
      model(r, e, m, dv);
      #1;
      n_cmp++;
      assert (q === 4'(mq)) else begin
         n_fail++;
         $error("FAIL %s q: got %0d expected %0d", tag, q, mq);
      end
      n_cmp++;
      assert (rco === mr) else begin
         n_fail++;
         $error("FAIL %s rco: got %0d expected %0d", tag, rco, mr);
      end
   endtask
   initial begin
      step("reset", 1, 1, 3, 9);
      repeat (17) step("up_wrap", 0, 1, 0, 0);
      step("reset2", 1, 0, 0, 0);
      repeat (5) step("down_wrap", 0, 1, 1, 0);
      step("load_b", 0, 1, 3, 11);
      repeat (5) step("down3", 0, 1, 2, 0);
      step("load_7", 0, 1, 3, 7);
      repeat (3) step("hold", 0, 0, $urandom_range(0, 3), $urandom_range(0, 15));
      step("hold_up", 0, 1, 0, 0);
      step("rst_load", 1, 1, 3, 15);
      step("after_rst", 0, 1, 3, 15);
      step("up_15", 0, 1, 0, 0);
      step("down_0", 0, 1, 1, 0);
      repeat (4) step("mid_cnt", 0, 1, 0, 0);
      step("mid_rst", 1, 1, 0, 0);
      step("resume", 0, 1, 0, 0);
      for (int i = 0; i < 400; i++)
         step("random", $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3), $urandom_range(0, 15));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
